fpu_result_packer: RTL
======================

Name: fpu_result_packer

Overview:
- Pack side of the FPU datapath: takes the rounded result in unpacked form (sign, biased exponent, 53-bit significand with hidden bit, special class, exception flags) and assembles the IEEE-754 word.
- Mirror of the operand unpacker that produces sa/ea/fa/lza.
- Sits between the rounder and the register-file writeback.
- Adds a valid/ready elastic stage (1-cycle latency, registered in_ready via a one-entry skid buffer) and a sticky IEEE exception-flag register.

Parameters:
- CNT_W, 16, width of the retired-result counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  unpacked result valid
- in_ready  output  1  packer can accept; registered
- in_s  input  1  result sign
- in_e  input  11  biased exponent; double uses all 11 bits, single uses in_e[7:0]
- in_f  input  53  significand; [52] is the hidden bit, [51:0] the fraction
- in_db  input  1  1 = double, 0 = single
- in_cls  input  2  00 finite, 01 zero, 10 infinity, 11 NaN
- in_flags  input  5  IEEp order: [4] INV, [3] DBZ, [2] OVF, [1] UNF, [0] INX
- out_valid  output  1  fp_out valid
- out_ready  input  1  consumer accepts
- fp_out  output  64  packed result
- ieee_sticky  output  5  OR of flags of all accepted results since reset or clear
- flag_clr  input  1  clears ieee_sticky
- res_cnt  output  CNT_W  number of accepted results, wraps

Behaviour:
- Reset (async, rst=1): out_valid=0, fp_out=0, ieee_sticky=0, res_cnt=0, skid empty, in_ready=1. In-flight results are dropped.
- Accept: in_valid && in_ready on a rising edge.
- Output register: loaded on accept if it is empty or being drained that cycle (out_valid && out_ready). Otherwise the accepted item goes into the skid buffer.
- Skid buffer: when full, in_ready=0 starting the next cycle. When the output drains, the skid contents move to the output register and in_ready returns to 1 the following cycle.
- Ordering: strictly FIFO; no reordering and no loss.
- Latency: accept at edge N gives out_valid=1 after edge N when the output path is free.
- While out_valid=1 && out_ready=0, fp_out is held stable.
- Packing, double (in_db=1):
  - finite: {in_s, E, in_f[51:0]}, where E=in_e if in_f[52]=1, else 11'h000 (denormal).
  - zero: {in_s, 63'b0}.
  - infinity: {in_s, 11'h7FF, 52'b0}.
  - NaN: 64'h7FF8_0000_0000_0000 (canonical quiet NaN, sign ignored).
- Packing, single (in_db=0):
  - result is placed in fp_out[63:32]; fp_out[31:0]=0.
  - finite: {in_s, E8, in_f[51:29]}, where E8=in_e[7:0] if in_f[52]=1, else 8'h00.
  - zero: {in_s, 31'b0}.
  - infinity: {in_s, 8'hFF, 23'b0}.
  - NaN: 32'h7FC0_0000.
- Width rule: the packer does not round or overflow-check. The rounder guarantees in_e < 11'h7FF (double) or < 8'hFF (single) for class finite.
- Sticky flags:
  - on accept, ieee_sticky <= ieee_sticky | in_flags.
  - flag_clr alone: ieee_sticky <= 0.
  - flag_clr and accept in the same cycle: ieee_sticky <= in_flags (the new flags survive the clear).
- res_cnt: increments on each accept; wraps from all-ones to 0.
- Simultaneous drain of output, skid->output move, and new accept: the skid refills; no bubble and no drop.

Decomposition:
- Shared package fpu_pkg holds:
  - class encoding enum (CLS_FIN, CLS_ZERO, CLS_INF, CLS_NAN)
  - flag bit indices (FLG_INV, FLG_DBZ, FLG_OVF, FLG_UNF, FLG_INX)
  - QNAN_D = 64'h7FF8000000000000 and QNAN_S = 32'h7FC00000
  - packed struct fpu_unpacked_t {s, e[10:0], f[52:0], db, cls, flags}
- Sub-module fpu_pack_comb: purely combinational struct-to-64-bit assembly, reusable by the unpacker bench as a reference model. The sequential elastic/skid logic stays in fpu_result_packer.

Test Plan:
- 6.0 double: in_s=0, in_e=11'h401, in_f={1'b1,52'h8000000000000}, cls=FIN, out_ready=1 -> fp_out=64'h4018000000000000 one cycle after accept.
- 6.0 single: in_db=0, in_e=11'h081, same in_f -> fp_out=64'h40C00000_00000000.
- Specials:
  - min denormal: in_f=53'h1, in_e=11'h001 -> 64'h0000000000000001.
  - NaN with in_s=1 -> 64'h7FF8000000000000.
  - -Inf double -> 64'hFFF0000000000000.
- Backpressure: out_ready=0, send three back-to-back results A, B, C.
  - A lands in the output register, B in the skid, in_ready drops; C must wait.
  - Raise out_ready -> A, B, C emerge in order, each held stable while stalled; res_cnt=3.
- Sticky flags:
  - accept flags 5'b00001, then 5'b00100 -> ieee_sticky=5'b00101.
  - flag_clr together with an accept carrying 5'b10000 -> ieee_sticky=5'b10000.
- Reset mid-stall with output and skid both full -> out_valid=0, in_ready=1, ieee_sticky=0 immediately (asynchronous); nothing emitted after release.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Brief    : Shared FPU types for the pack/unpack datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [1:0] {
        CLS_FIN  = 2'b00,
        CLS_ZERO = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } fpu_cls_e;

    localparam int FLG_INV = 4;
    localparam int FLG_DBZ = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] QNAN_S = 32'h7FC0_0000;

    typedef struct packed {
        logic        s;
        logic [10:0] e;
        logic [52:0] f;
        logic        db;
        fpu_cls_e    cls;
        logic [4:0]  flags;
    } fpu_unpacked_t;

endpackage
`default_nettype wire

// File: rtl/fpu_pack_comb.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pack_comb
//  Brief    : Combinational assembly of an unpacked result into an IEEE word.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_pack_comb
    import fpu_pkg::*;
(
    input  fpu_unpacked_t i_res,
    output logic [63:0]   o_word,
    output logic [4:0]    o_flags
);

    logic [10:0] w_e_d;
    logic [7:0]  w_e_s;

    // A clear hidden bit marks a denormal, whose stored exponent is zero.
    assign w_e_d   = i_res.f[52] ? i_res.e      : 11'h000;
    assign w_e_s   = i_res.f[52] ? i_res.e[7:0] : 8'h00;
    assign o_flags = i_res.flags;

    always_comb begin
        o_word = '0;
        if (i_res.db) begin
            case (i_res.cls)
                CLS_FIN:  o_word = {i_res.s, w_e_d, i_res.f[51:0]};
                CLS_ZERO: o_word = {i_res.s, 63'b0};
                CLS_INF:  o_word = {i_res.s, 11'h7FF, 52'b0};
                default:  o_word = QNAN_D;
            endcase
        end else begin
            case (i_res.cls)
                CLS_FIN:  o_word[63:32] = {i_res.s, w_e_s, i_res.f[51:29]};
                CLS_ZERO: o_word[63:32] = {i_res.s, 31'b0};
                CLS_INF:  o_word[63:32] = {i_res.s, 8'hFF, 23'b0};
                default:  o_word[63:32] = QNAN_S;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_result_packer
//  Brief    : Elastic pack stage between rounder and writeback, with sticky
//             IEEE flags and a retired-result counter.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_result_packer
    import fpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_s,
    input  logic [10:0]      in_e,
    input  logic [52:0]      in_f,
    input  logic             in_db,
    input  logic [1:0]       in_cls,
    input  logic [4:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      fp_out,
    output logic [4:0]       ieee_sticky,
    input  logic             flag_clr,
    output logic [CNT_W-1:0] res_cnt
);

    fpu_unpacked_t    w_in;
    logic [63:0]      w_word;
    logic [4:0]       w_flags;
    logic             w_accept;
    logic             w_drain;
    logic             w_out_free;

    logic             r_out_valid;
    logic [63:0]      r_fp_out;
    logic             r_skid_valid;
    logic [63:0]      r_skid_word;
    logic [4:0]       r_sticky;
    logic [CNT_W-1:0] r_cnt;

    assign w_in = '{s: in_s, e: in_e, f: in_f, db: in_db,
                    cls: fpu_cls_e'(in_cls), flags: in_flags};

    fpu_pack_comb u_pack (
        .i_res   (w_in),
        .o_word  (w_word),
        .o_flags (w_flags)
    );

    // Ready depends only on skid occupancy, so it is a registered signal.
    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & in_ready;
    assign w_drain     = r_out_valid & out_ready;
    assign w_out_free  = ~r_out_valid | w_drain;

    assign out_valid   = r_out_valid;
    assign fp_out      = r_fp_out;
    assign ieee_sticky = r_sticky;
    assign res_cnt     = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_fp_out     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_word  <= '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Older skid entry goes first; a new accept refills the skid.
                r_fp_out     <= r_skid_word;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid_word <= w_word;
                end
            end else if (w_accept) begin
                r_fp_out    <= w_word;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_word  <= w_word;
            r_skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
            r_cnt    <= '0;
        end else begin
            // Flags arriving with a clear survive it.
            if (flag_clr) begin
                r_sticky <= w_accept ? w_flags : 5'b0;
            end else if (w_accept) begin
                r_sticky <= r_sticky | w_flags;
            end
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
